axi4_lite_read_master: RTL

AXI4_LITE_READ_MASTER -- requirements
Module: axi4_lite_read_master

---
 rtl/axi4_lite_read_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi4_lite_read_master.sv
// axi4_lite_read_master: single-outstanding AXI4-Lite read master.
// A core request is turned into one AR/R exchange and answered with a one-cycle
// rsp_valid pulse carrying the read data and an error flag.
// Optional feature: define AXI4_READ_TIMEOUT_EN to abort a transaction that has
// spent TIMEOUT_CYCLES cycles in ADDR/DATA (answered with rsp_data 0, rsp_error 1).
module axi4_lite_read_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     axi_clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     req_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_error
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_data_q, rsp_data_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     timeout;

    // Only the SLVERR/DECERR bit of rresp matters; OKAY and EXOKAY are both success.
    logic unused_rresp;
    assign unused_rresp = rresp[0];

`ifdef AXI4_READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    assign busy = (state_q == ADDR) || (state_q == DATA);

    // Count every cycle the transaction is outstanding; zero whenever it is not,
    // so the counter is already clear when the FSM re-enters IDLE.
    always_comb begin
        cnt_d = '0;
        if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q == TIMEOUT_CYCLES-1 marks the last allowed outstanding cycle.
    assign timeout = busy && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout    = 1'b0;
`endif

    // Next-state and next-output logic; a handshake wins over a coincident timeout.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ADDR;
                    araddr_d = req_addr;
                end
            end
            ADDR: begin
                if (arvalid_q && arready) begin
                    state_d = DATA;
                end else if (timeout) begin
                    state_d     = RESP;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                end
            end
            DATA: begin
                if (rvalid && rready_q) begin
                    state_d     = RESP;
                    rsp_data_d  = rdata;
                    rsp_error_d = rresp[1];
                end else if (timeout) begin
                    state_d     = RESP;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake outputs are decoded from the next state so they come straight
        // from flops and never depend combinationally on arready/rvalid.
        arvalid_d   = (state_d == ADDR);
        rready_d    = (state_d == DATA);
        rsp_valid_d = (state_d == RESP);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
`ifdef AXI4_READ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
`ifdef AXI4_READ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Ready only in IDLE, and forced low for as long as reset is held.
    assign req_ready = (state_q == IDLE) && !reset;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;

endmodule
